button_press_ctrl: RTL and testbench

- Sits directly downstream of the 4-button debouncer and consumes its stable, already-synchronised, active-low button levels.
- Classifies each button press as short or long and emits one-cycle event pulses.
- Drives 4 active-low LEDs: a short press toggles that LED on/off; a long press toggles that LED's blink mode.
- All four buttons are independent; a single global blink phase keeps all blinking LEDs in step.

---
 rtl/button_press_ctrl.sv | 143 ++++++++++++++
 tb/tb_button_press_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_press_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : button_press_ctrl
//  Description : Classifies debounced, active-low button presses as short or
//                long, emits one-cycle event pulses and drives four active-low
//                LEDs. A short press toggles an LED on/off; a long press
//                toggles its blink mode. All blinking LEDs share one phase.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          system clock
//    rst_n        asynchronous active-low reset
//    btn_n[3:0]   debounced button levels, 0 = pressed, already in clk domain
//    short_pulse  one-cycle pulse when a short press is released
//    long_pulse   one-cycle pulse when a held press crosses LONG_LIMIT
//    led_on       per-LED enable state
//    blink_en     per-LED blink-mode state
//    led_n        registered LED drive, 0 = lit
// ============================================================================
module button_press_ctrl #(
    parameter int LONG_LIMIT = 8,
    parameter int BLINK_HALF = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_n,
    output logic [3:0] short_pulse,
    output logic [3:0] long_pulse,
    output logic [3:0] led_on,
    output logic [3:0] blink_en,
    output logic [3:0] led_n
);

    localparam int CNT_W = (LONG_LIMIT > 1) ? $clog2(LONG_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LONG_LIMIT - 1);

    localparam int BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);

    // Per-button press classifier states
    localparam logic [1:0] ST_WAIT_REL = 2'd0;  // must see a release first
    localparam logic [1:0] ST_IDLE     = 2'd1;  // released, waiting for a press
    localparam logic [1:0] ST_HOLD     = 2'd2;  // pressed, counting held cycles

    // ------------------------------------------------------------------------
    // Per-button classifier and LED state
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < 4; i++) begin : g_btn
        logic [1:0]       r_state;
        logic [CNT_W-1:0] r_cnt;
        logic             r_short;
        logic             r_long;
        logic             r_led_on;
        logic             r_blink_en;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state    <= ST_WAIT_REL;
                r_cnt      <= '0;
                r_short    <= 1'b0;
                r_long     <= 1'b0;
                r_led_on   <= 1'b0;
                r_blink_en <= 1'b0;
            end else begin
                r_short <= 1'b0;
                r_long  <= 1'b0;
                case (r_state)
                    ST_WAIT_REL: begin
                        // A press still held (through reset or after a long
                        // event) is ignored until the button comes back up.
                        if (btn_n[i]) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_IDLE: begin
                        if (!btn_n[i]) begin
                            r_state <= ST_HOLD;
                            r_cnt   <= '0;
                        end
                    end
                    ST_HOLD: begin
                        // Release wins over reaching the limit on the same edge.
                        if (btn_n[i]) begin
                            r_short  <= 1'b1;
                            r_led_on <= ~r_led_on;
                            r_state  <= ST_IDLE;
                        end else if (r_cnt == CNT_LAST) begin
                            r_long     <= 1'b1;
                            r_blink_en <= ~r_blink_en;
                            r_state    <= ST_WAIT_REL;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_WAIT_REL;
                    end
                endcase
            end
        end

        assign short_pulse[i] = r_short;
        assign long_pulse[i]  = r_long;
        assign led_on[i]      = r_led_on;
        assign blink_en[i]    = r_blink_en;
    end

    // ------------------------------------------------------------------------
    // Free-running blink phase shared by all LEDs
    // ------------------------------------------------------------------------
    logic [BLK_W-1:0] r_blink_cnt;
    logic             r_blink_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == BLK_LAST) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLK_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // LED drive: lit when enabled and either steady or in the lit blink phase.
    // Blink mode with the LED disabled stays dark but is remembered.
    // ------------------------------------------------------------------------
    logic [3:0] r_led_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led_n <= 4'b1111;
        end else begin
            r_led_n <= ~(led_on & (~blink_en | {4{r_blink_phase}}));
        end
    end

    assign led_n = r_led_n;

endmodule
`default_nettype wire

// File: tb/tb_button_press_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_press_ctrl
//  Description : Self-checking bench for button_press_ctrl. A press-level
//                model (consecutive-low-sample counting) predicts every output
//                on every cycle; directed literal checks pin key events.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_button_press_ctrl;

    localparam int LL = 8;
    localparam int BH = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn_n;
    logic [3:0] short_pulse;
    logic [3:0] long_pulse;
    logic [3:0] led_on;
    logic [3:0] blink_en;
    logic [3:0] led_n;

    button_press_ctrl #(
        .LONG_LIMIT (LL),
        .BLINK_HALF (BH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_n       (btn_n),
        .short_pulse (short_pulse),
        .long_pulse  (long_pulse),
        .led_on      (led_on),
        .blink_en    (blink_en),
        .led_n       (led_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------------
    // Press-level model: a button becomes eligible only after it has been seen
    // released; each eligible press counts low samples. The (LL+1)-th low
    // sample is a long event; a high sample after 1..LL lows is a short event.
    // ------------------------------------------------------------------------
    int         m_lows [4];
    bit         m_block[4];
    logic [3:0] m_short, m_long, m_on, m_blink, m_led_n;
    int         m_cycles;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_lows[i]  = 0;
            m_block[i] = 1'b1;
        end
        m_short  = '0;
        m_long   = '0;
        m_on     = '0;
        m_blink  = '0;
        m_led_n  = 4'hF;
        m_cycles = 0;
    endtask

    task automatic model_step(input logic [3:0] b);
        logic phase;
        phase   = ((m_cycles / BH) % 2) == 1;
        m_led_n = ~(m_on & (~m_blink | {4{phase}}));
        m_short = '0;
        m_long  = '0;
        for (int i = 0; i < 4; i++) begin
            if (m_block[i]) begin
                if (b[i]) m_block[i] = 1'b0;
            end else if (!b[i]) begin
                m_lows[i]++;
                if (m_lows[i] == LL + 1) begin
                    m_long[i]  = 1'b1;
                    m_block[i] = 1'b1;
                    m_lows[i]  = 0;
                end
            end else begin
                if (m_lows[i] > 0) m_short[i] = 1'b1;
                m_lows[i] = 0;
            end
        end
        m_on     = m_on ^ m_short;
        m_blink  = m_blink ^ m_long;
        m_cycles = m_cycles + 1;
    endtask

    // Compare process: every cycle, 1 time unit after the rising edge.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) model_reset();
            else        model_step(btn_n);
            chk("cyc_short_pulse", short_pulse, m_short);
            chk("cyc_long_pulse",  long_pulse,  m_long);
            chk("cyc_led_on",      led_on,      m_on);
            chk("cyc_blink_en",    blink_en,    m_blink);
            chk("cyc_led_n",       led_n,       m_led_n);
        end
    end

    // Hold btn_n at v for the given number of rising edges; returns at a falling edge.
    task automatic drive(input logic [3:0] v, input int cycles);
        btn_n = v;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        int   toggles;
        logic prev;

        rst_n = 1'b0;
        btn_n = 4'b1110;
        repeat (3) @(negedge clk);
        chk("rst_led_n", led_n, 4'b1111);
        chk("rst_pulses", short_pulse | long_pulse, 4'b0000);

        // Held through reset: no event from bit0
        rst_n = 1'b1;
        drive(4'b1110, 20);
        chk("held_led_n", led_n, 4'b1111);
        chk("held_long", long_pulse, 4'b0000);
        drive(4'b1111, 2);
        chk("held_rel_short", short_pulse, 4'b0000);

        // Short press on bit1, 3 low edges
        drive(4'b1101, 3);
        drive(4'b1111, 1);
        chk("short1_pulse", short_pulse, 4'b0010);
        chk("short1_led_on", led_on, 4'b0010);
        drive(4'b1111, 1);
        chk("short1_pulse_gone", short_pulse, 4'b0000);
        chk("short1_led_n", led_n, 4'b1101);
        drive(4'b1101, 3);
        drive(4'b1111, 3);
        chk("short1b_led_n", led_n, 4'b1111);
        chk("short1b_led_on", led_on, 4'b0000);

        // Boundary on bit2: 8 lows is short, 9 lows is long
        drive(4'b1011, 8);
        drive(4'b1111, 1);
        chk("b8_short", short_pulse, 4'b0100);
        chk("b8_long", long_pulse, 4'b0000);
        drive(4'b1111, 2);
        drive(4'b1011, 8);
        chk("b9_not_yet", long_pulse, 4'b0000);
        drive(4'b1011, 1);
        chk("b9_long", long_pulse, 4'b0100);
        chk("b9_blink_en", blink_en, 4'b0100);
        drive(4'b1111, 1);
        chk("b9_rel_short", short_pulse, 4'b0000);
        drive(4'b1111, 2);

        // Blink on bit3: short then long
        drive(4'b0111, 2);
        drive(4'b1111, 2);
        drive(4'b0111, 9);
        drive(4'b1111, 1);
        chk("blk_led_on", led_on & 4'b1000, 4'b1000);
        chk("blk_blink_en", blink_en & 4'b1000, 4'b1000);
        toggles = 0;
        prev    = led_n[3];
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (led_n[3] !== prev) toggles++;
            prev = led_n[3];
        end
        chk_int("blk_toggles", toggles, 4);
        drive(4'b0111, 9);
        drive(4'b1111, 2);
        chk("steady_blink_en", blink_en & 4'b1000, 4'b0000);
        chk("steady_led_n3", led_n & 4'b1000, 4'b0000);

        // Simultaneous: bit0 short release on the same edge as bit1 long
        drive(4'b1101, 5);
        drive(4'b1100, 3);
        drive(4'b1101, 1);
        chk("sim_short", short_pulse, 4'b0001);
        chk("sim_long", long_pulse, 4'b0010);
        drive(4'b1111, 2);
        // Two short presses released on the same edge
        drive(4'b1100, 3);
        drive(4'b1111, 1);
        chk("sim2_short", short_pulse, 4'b0011);
        drive(4'b1111, 2);

        // Reset in the middle of a bit0 hold (cnt = 5)
        drive(4'b1110, 6);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_led_n", led_n, 4'b1111);
        chk("mid_rst_led_on", led_on, 4'b0000);
        chk("mid_rst_blink", blink_en, 4'b0000);
        chk("mid_rst_pulses", short_pulse | long_pulse, 4'b0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(4'b1110, 12);
        chk("post_rst_long", long_pulse, 4'b0000);
        drive(4'b1111, 1);
        chk("post_rst_short", short_pulse, 4'b0000);
        drive(4'b1110, 3);
        drive(4'b1111, 1);
        chk("post_rst_press", short_pulse, 4'b0001);
        drive(4'b1111, 4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
